cpa: RTL and testbench
======================

# cpa

Carry-propagate adder: the final 32-bit adder stage of the Wallace-tree multiplier datapath. It adds the two vectors left by the carry-save reduction tree into one binary sum plus carry-out. The carry network is a two-level carry-lookahead structure and the result is registered, so the block drops into the pipelined multiplier as one stage.

## Interface
Parameters: none. Width is fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- x  input  32  addend A, unsigned
- y  input  32  addend B, unsigned
- sum  output  32  registered (x + y) mod 2^32
- cout  output  1  registered carry out of bit 31

## Operation
- Arithmetic is unsigned. {cout, sum} = x + y, using a 33-bit result. Carry-in is hard-wired to 0.
- Bit level:
  - p[i] = x[i] ^ y[i]
  - g[i] = x[i] & y[i]
  - sum[i] = p[i] ^ c[i]
  - c[0] = 0
- First level: eight 4-bit carry-lookahead groups.
  - Each group computes internal carries from its own p/g and the group carry-in.
  - Each group also produces a group propagate P = p3&p2&p1&p0.
  - Each group produces a group generate G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Second level: a lookahead unit takes the eight (P, G) pairs and c[0], and produces group carry-ins c[4], c[8], …, c[28], plus c[32].
- cout = c[32].
- No carry path may ripple through more than one group.
- The combinational result D_sum / D_cout is loaded into the output registers every clock when rst = 0. There is no enable and no hold.
- Overflow (x + y ≥ 2^32): sum wraps modulo 2^32 and cout = 1. No saturation and no flag other than cout.
- X or Z on the inputs is not supported. The inputs are driven by the registered reduction tree.

## Timing
- Latency is 1 cycle. Inputs are sampled at rising edge N, and sum/cout show the result from edge N until edge N+1.
- Throughput is one addition per cycle. A new operand pair may be applied every cycle.
- Reset:
  - On any rising edge with rst = 1, sum = 32'h0 and cout = 0, whatever x and y are.
  - Reset takes priority over the add.
  - The first valid result appears one edge after rst is deasserted, for the operands present on that edge.
- Reset in the middle of a stream: the result that would have been registered on the reset edge is lost. The next edge with rst = 0 loads normally.
- Power-up, before the first reset edge: output values are undefined. The bench must apply reset first.
- The combinational path x/y → p/g → group P/G → second-level lookahead → group carries → sum bit → register must close within one clock period. That path is about 3 lookahead levels deep, not 32 ripple stages.

## Test plan
- Reset: hold rst = 1 for 2 edges with x = 32'hFFFFFFFF, y = 1 → sum = 0, cout = 0. Release rst; the next edge gives sum = 0, cout = 1.
- Small operands, applied one per cycle with results checked one edge later:
  - 0+0 → 0
  - 1+1 → 2
  - 2+2 → 4
  - 4+1 → 5
  - 12+71 → 83
  - 62+12 → 74
  - 5+16 → 21
  - cout = 0 for all of these.
- Group-boundary carry: x = 32'h0000FFFF, y = 32'h0000FFFF → sum = 32'h0001FFFE, cout = 0. x = 32'h0000000F, y = 1 → sum = 32'h10.
- Full-width carry chain:
  - x = 32'hFFFFFFFF, y = 1 → sum = 0, cout = 1.
  - x = 32'hFFFFFFFF, y = 32'hFFFFFFFF → sum = 32'hFFFFFFFE, cout = 1.
  - x = 32'h80000000, y = 32'h80000000 → sum = 0, cout = 1.
- Back-to-back pipeline: change the operands every cycle for 1000 random pairs. Each registered {cout, sum} must equal the 33-bit reference x + y from the previous edge.
- Mid-stream reset: assert rst for one edge during the random stream. That edge's output = 0/0, and correct results resume on the following edge.

Source files
------------

// File: rtl/cpa.sv
// Registered 32-bit carry-propagate adder for the multiplier back end.
// Two-level carry lookahead: eight 4-bit groups under one lookahead unit.
module cpa (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] sum,
  output logic        cout
);

  localparam logic C0 = 1'b0;

  logic [31:0] p;
  logic [31:0] g;
  logic [32:0] c;
  logic [7:0]  gp;
  logic [7:0]  gg;
  logic [8:0]  gc;

  logic [31:0] sum_d, sum_q;
  logic        cout_d, cout_q;

  assign p = x ^ y;
  assign g = x & y;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    logic ci;

    assign ci = gc[k];

    assign gp[k] = &p[B+3:B];
    assign gg[k] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);

    assign c[B]   = ci;
    assign c[B+1] = g[B]
                  | (p[B] & ci);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & ci);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & ci);
  end

  assign c[32] = gc[8];

  // Each group carry is a flat sum of products over all lower groups,
  // so no carry passes serially through more than one group.
  always_comb begin
    logic term;
    logic acc;
    term  = 1'b0;
    acc   = 1'b0;
    gc    = '0;
    gc[0] = C0;
    for (int k = 0; k < 8; k++) begin
      term = C0;
      for (int j = 0; j <= k; j++) term = term & gp[j];
      acc = term;
      for (int j = 0; j <= k; j++) begin
        term = gg[j];
        for (int m = j + 1; m <= k; m++) term = term & gp[m];
        acc = acc | term;
      end
      gc[k+1] = acc;
    end
  end

  assign sum_d  = p ^ c[31:0];
  assign cout_d = c[32];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cpa.sv
// Bench for cpa: directed vector table, reset sequences and a random
// back-to-back stream, all checked through an expected-result queue.
module tb_cpa;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] sum;
  logic        cout;

  int checks;
  int errors;

  logic [32:0] exp_q[$];
  int          tag_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] e;
  } vec_t;

  vec_t vecs[12];

  cpa dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [31:0] a,
                      input logic [31:0] b, input logic [32:0] e,
                      input int tag);
    logic [32:0] want;
    int          t;
    rst = r;
    x   = a;
    y   = b;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty tag=%0d", tag);
    end else begin
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      if ({cout, sum} !== want) begin
        errors++;
        $display("FAIL vec%0d x=%h y=%h rst=%b got cout=%b sum=%h want cout=%b sum=%h",
                 t, a, b, r, cout, sum, want[32], want[31:0]);
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    x   = '0;
    y   = '0;

    vecs[0]  = '{32'd0, 32'd0, 33'd0};
    vecs[1]  = '{32'd1, 32'd1, 33'd2};
    vecs[2]  = '{32'd2, 32'd2, 33'd4};
    vecs[3]  = '{32'd4, 32'd1, 33'd5};
    vecs[4]  = '{32'd12, 32'd71, 33'd83};
    vecs[5]  = '{32'd62, 32'd12, 33'd74};
    vecs[6]  = '{32'd5, 32'd16, 33'd21};
    vecs[7]  = '{32'h0000FFFF, 32'h0000FFFF, 33'h0_0001FFFE};
    vecs[8]  = '{32'h0000000F, 32'h00000001, 33'h0_00000010};
    vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, 33'h1_00000000};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1_FFFFFFFE};
    vecs[11] = '{32'h80000000, 32'h80000000, 33'h1_00000000};

    #1;
    // Reset held two edges with operands that would overflow.
    step(1'b1, 32'hFFFFFFFF, 32'h1, 33'h0, 100);
    step(1'b1, 32'hFFFFFFFF, 32'h1, 33'h0, 101);
    step(1'b0, 32'hFFFFFFFF, 32'h1, 33'h1_00000000, 102);

    for (int i = 0; i < 12; i++)
      step(1'b0, vecs[i].a, vecs[i].b, vecs[i].e, i);

    // Reset on a single edge mid-stream, then resume.
    step(1'b1, 32'h12345678, 32'hFFFFFFFF, 33'h0, 200);
    step(1'b0, 32'h12345678, 32'hFFFFFFFF, 33'h1_12345677, 201);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 500)
        step(1'b1, ra, rb, 33'h0, 1000 + i);
      else
        step(1'b0, ra, rb, {1'b0, ra} + {1'b0, rb}, 1000 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
